sig_gen_ctrl: RTL and testbench

Sequencer for the signal generator's sample-memory datapath. Holds the playback rate divider and adjusts it from debounced faster/slower button pulses. Issues a one-cycle inc_data strobe per sample period, drives the waveform ROM address, and realigns the ROM read data into a registered sample with a valid pulse. Sits between the button debouncers, the signal_memory ROM and the GPIO/DAC output stage.

---
 rtl/sig_gen_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_sig_gen_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_gen_ctrl.sv
// -----------------------------------------------------------------------------
// sig_gen_ctrl
//
// Playback sequencer for the signal generator's sample-memory datapath.
//
// The block walks the waveform ROM one address per sample period. It keeps
// two copies of the rate divider:
//   - div_pend: the value the operator is adjusting with the faster/slower
//     buttons.
//   - div_now:  the value actually timing the current period.
// div_pend is copied into div_now only at a period boundary, in PRIME, or
// while idle. A button press therefore never produces a truncated or
// stretched period.
//
// Every address the sequencer wants played issues a read strobe. The strobe
// travels down a ROM_LAT-deep valid pipe alongside the ROM access. When it
// leaves the pipe, rom_q is captured into the registered sample and
// sample_valid pulses for one cycle.
//
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active low
//   en           run enable (level)
//   clr          one-cycle pulse: restart the waveform at address 0
//   sw_up        one-cycle pulse: faster (smaller divider)
//   sw_down      one-cycle pulse: slower (larger divider)
//   rom_q        ROM read data, valid ROM_LAT cycles after rom_addr changes
//   rom_addr     registered ROM address
//   inc_data     one-cycle strobe on every address advance
//   sample       registered output sample
//   sample_valid one-cycle strobe when sample is updated
//   div_now      divider timing the current period
//   at_min       pending divider sits at DIV_MIN
//   at_max       pending divider sits at DIV_MAX
//   running      high while in the RUN state
// -----------------------------------------------------------------------------
module sig_gen_ctrl #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned DIV_INIT = 1000,
  parameter int unsigned DIV_MIN  = 10,
  parameter int unsigned DIV_MAX  = 50000,
  parameter int unsigned ROM_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              sw_up,
  input  logic              sw_down,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              inc_data,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic [DIV_W-1:0]  div_now,
  output logic              at_min,
  output logic              at_max,
  output logic              running
);

  // Sized constants. The rate arithmetic runs one bit wider than the divider
  // so that neither the add nor the subtract can wrap before clamping.
  localparam logic [DIV_W-1:0]  DIV_INIT_V = DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0]  DIV_MIN_V  = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0]  DIV_MAX_V  = DIV_W'(DIV_MAX);
  localparam logic [DIV_W:0]    DIV_MIN_X  = (DIV_W+1)'(DIV_MIN);
  localparam logic [DIV_W:0]    DIV_MAX_X  = (DIV_W+1)'(DIV_MAX);
  localparam logic [DIV_W:0]    STEP_ONE   = (DIV_W+1)'(1);
  localparam logic [DIV_W:0]    STEP_ZERO  = (DIV_W+1)'(0);
  localparam logic [DIV_W-1:0]  CNT_ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0]  CNT_ZERO   = DIV_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = ADDR_W'(0);
  localparam logic [ROM_LAT-1:0] PIPE_ZERO = ROM_LAT'(0);
  localparam logic [DATA_W-1:0] DATA_ZERO  = DATA_W'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Rate step is one eighth of the current divider, but never less than one.
  // Without the floor, small dividers could never move.
  function automatic logic [DIV_W:0] rate_step(input logic [DIV_W-1:0] pend);
    logic [DIV_W:0] step;
    step = {1'b0, pend} >> 3;
    if (step == STEP_ZERO) begin
      step = STEP_ONE;
    end
    return step;
  endfunction

  // Faster: subtract the step and clamp at DIV_MIN.
  function automatic logic [DIV_W-1:0] rate_faster(input logic [DIV_W-1:0] pend);
    logic [DIV_W:0] ext;
    logic [DIV_W:0] step;
    logic [DIV_W:0] res;
    ext  = {1'b0, pend};
    step = rate_step(pend);
    if (ext < (step + DIV_MIN_X)) begin
      res = DIV_MIN_X;
    end else begin
      res = ext - step;
    end
    return DIV_W'(res);
  endfunction

  // Slower: add the step and clamp at DIV_MAX.
  function automatic logic [DIV_W-1:0] rate_slower(input logic [DIV_W-1:0] pend);
    logic [DIV_W:0] res;
    res = {1'b0, pend} + rate_step(pend);
    if (res > DIV_MAX_X) begin
      res = DIV_MAX_X;
    end
    return DIV_W'(res);
  endfunction

  state_t              state_r, state_s;
  logic [DIV_W-1:0]    cnt_r, cnt_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                inc_r, inc_s;
  logic                strobe_s;
  logic [DIV_W-1:0]    div_now_r, div_now_s;
  logic [DIV_W-1:0]    div_pend_r, div_pend_s;
  logic                at_min_r, at_min_s;
  logic                at_max_r, at_max_s;
  logic                running_r, running_s;
  logic [ROM_LAT-1:0]  vpipe_r, vpipe_s;
  logic [DATA_W-1:0]   sample_r, sample_s;
  logic                valid_r, valid_s;

  // Sequencer next state: period counter, address walk, read strobes, divider handover
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    addr_s    = addr_r;
    inc_s     = 1'b0;
    strobe_s  = 1'b0;
    div_now_s = div_now_r;
    case (state_r)
      IDLE: begin
        // While idle, div_now tracks div_pend so the display is live.
        cnt_s     = CNT_ZERO;
        div_now_s = div_pend_r;
        if (clr) begin
          addr_s = ADDR_ZERO;
        end else begin
          addr_s = addr_r;
        end
        if (en) begin
          state_s = PRIME;
        end else begin
          state_s = IDLE;
        end
      end
      PRIME: begin
        // Re-read the current address so the first sample is not stale.
        // The address does not advance and no inc_data is issued.
        cnt_s     = CNT_ZERO;
        div_now_s = div_pend_r;
        strobe_s  = 1'b1;
        state_s   = RUN;
        if (clr) begin
          addr_s = ADDR_ZERO;
        end else begin
          addr_s = addr_r;
        end
      end
      RUN: begin
        if (!en) begin
          // Leave without advancing. Reads already in flight still complete.
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          if (clr) begin
            addr_s = ADDR_ZERO;
          end else begin
            addr_s = addr_r;
          end
        end else if (clr) begin
          // clr takes priority over a coincident terminal count.
          addr_s   = ADDR_ZERO;
          cnt_s    = CNT_ZERO;
          strobe_s = 1'b1;
        end else if (cnt_r == (div_now_r - CNT_ONE)) begin
          cnt_s     = CNT_ZERO;
          addr_s    = addr_r + ADDR_ONE;
          inc_s     = 1'b1;
          div_now_s = div_pend_r;
          strobe_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
    running_s = (state_s == RUN);
  end

  // Pending divider update from the button pulses. Simultaneous presses cancel.
  always_comb begin
    if (sw_up && !sw_down) begin
      div_pend_s = rate_faster(div_pend_r);
    end else if (sw_down && !sw_up) begin
      div_pend_s = rate_slower(div_pend_r);
    end else begin
      div_pend_s = div_pend_r;
    end
    at_min_s = (div_pend_s == DIV_MIN_V);
    at_max_s = (div_pend_s == DIV_MAX_V);
  end

  // Read valid pipe and sample capture aligned to the ROM latency
  always_comb begin
    vpipe_s    = PIPE_ZERO;
    vpipe_s[0] = strobe_s;
    for (int i = 1; i < ROM_LAT; i++) begin
      vpipe_s[i] = vpipe_r[i-1];
    end
    if (vpipe_r[ROM_LAT-1]) begin
      sample_s = rom_q;
    end else begin
      sample_s = sample_r;
    end
    valid_s = vpipe_r[ROM_LAT-1];
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      addr_r     <= ADDR_ZERO;
      inc_r      <= 1'b0;
      div_now_r  <= DIV_INIT_V;
      div_pend_r <= DIV_INIT_V;
      at_min_r   <= (DIV_INIT_V == DIV_MIN_V);
      at_max_r   <= (DIV_INIT_V == DIV_MAX_V);
      running_r  <= 1'b0;
      vpipe_r    <= PIPE_ZERO;
      sample_r   <= DATA_ZERO;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      addr_r     <= addr_s;
      inc_r      <= inc_s;
      div_now_r  <= div_now_s;
      div_pend_r <= div_pend_s;
      at_min_r   <= at_min_s;
      at_max_r   <= at_max_s;
      running_r  <= running_s;
      vpipe_r    <= vpipe_s;
      sample_r   <= sample_s;
      valid_r    <= valid_s;
    end
  end

  assign rom_addr     = addr_r;
  assign inc_data     = inc_r;
  assign sample       = sample_r;
  assign sample_valid = valid_r;
  assign div_now      = div_now_r;
  assign at_min       = at_min_r;
  assign at_max       = at_max_r;
  assign running      = running_r;

endmodule

// File: tb/tb_sig_gen_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sig_gen_ctrl
//
// Bench for sig_gen_ctrl. It uses a small table length and divider
// (ADDR_W=4, DIV_INIT=8, DIV_MIN=4) so that wrap and clamping are reached
// quickly.
//
// A behavioural model tracks the expected outputs from the sequencing rules.
// A compare process checks all outputs against the model every cycle. Directed
// steps add literal expectations that pin the model itself.
// -----------------------------------------------------------------------------
module tb_sig_gen_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DIV_W  = 16;
  localparam int D_INIT = 8;
  localparam int D_MIN  = 4;
  localparam int D_MAX  = 50000;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst_n, en, clr, sw_up, sw_down;
  logic [DATA_W-1:0] rom_q;
  logic [ADDR_W-1:0] rom_addr;
  logic              inc_data, sample_valid, at_min, at_max, running;
  logic [DATA_W-1:0] sample;
  logic [DIV_W-1:0]  div_now;

  int checks   = 0;
  int failures = 0;

  sig_gen_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W), .DIV_INIT(D_INIT),
    .DIV_MIN(D_MIN), .DIV_MAX(D_MAX), .ROM_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sw_up(sw_up),
    .sw_down(sw_down), .rom_q(rom_q), .rom_addr(rom_addr),
    .inc_data(inc_data), .sample(sample), .sample_valid(sample_valid),
    .div_now(div_now), .at_min(at_min), .at_max(at_max), .running(running)
  );

  always #10 clk = ~clk;

  // Waveform table contents: an arbitrary pattern, distinct per address.
  function automatic logic [15:0] rom_val(input int a);
    return 16'((a * 4099 + 4660) & 16'hFFFF);
  endfunction

  // ROM stand-in: address registered, data valid before the second edge.
  always @(posedge clk) rom_q <= rom_val(int'(rom_addr));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; int addr; } rd_t;
  rd_t rdq[$];
  int  cyc = 0;
  bit  live = 0;
  int  m_mode, m_cnt, m_addr, m_pend, m_now;   // m_mode: 0 idle, 1 prime, 2 run
  bit  e_inc, e_sv, e_run, e_min, e_max;
  logic [15:0] e_sample;

  function automatic int next_pend(input int p, input bit up, input bit dn);
    int s;
    s = p / 8;
    if (s < 1) s = 1;
    if (up && !dn) begin
      p = p - s;
      if (p < D_MIN) p = D_MIN;
    end else if (dn && !up) begin
      p = p + s;
      if (p > D_MAX) p = D_MAX;
    end
    return p;
  endfunction

  task automatic model_step();
    bit strobe;
    cyc++;
    if (!rst_n) begin
      live = 1; m_mode = 0; m_cnt = 0; m_addr = 0; m_pend = D_INIT; m_now = D_INIT;
      e_inc = 0; e_sv = 0; e_sample = 16'd0;
      rdq.delete();
    end else if (live) begin
      strobe = 0; e_inc = 0; e_sv = 0;
      if (rdq.size() > 0) begin
        if (rdq[0].due == cyc) begin
          e_sample = rom_val(rdq[0].addr);
          e_sv = 1;
          void'(rdq.pop_front());
        end
      end
      case (m_mode)
        0: begin
          m_now = m_pend; m_cnt = 0;
          if (clr) m_addr = 0;
          if (en) m_mode = 1;
        end
        1: begin
          m_now = m_pend; m_cnt = 0;
          if (clr) m_addr = 0;
          strobe = 1; m_mode = 2;
        end
        default: begin
          if (!en) begin
            m_mode = 0; m_cnt = 0;
            if (clr) m_addr = 0;
          end else if (clr) begin
            m_addr = 0; m_cnt = 0; strobe = 1;
          end else if (m_cnt == m_now - 1) begin
            m_cnt = 0; m_addr = (m_addr + 1) % (1 << ADDR_W);
            e_inc = 1; m_now = m_pend; strobe = 1;
          end else begin
            m_cnt++;
          end
        end
      endcase
      if (strobe) rdq.push_back('{due: cyc + LAT, addr: m_addr});
      m_pend = next_pend(m_pend, sw_up, sw_down);
    end
    e_run = (m_mode == 2);
    e_min = (m_pend == D_MIN);
    e_max = (m_pend == D_MAX);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(posedge clk);
    #1;
    if (live) begin
      chk("cyc_rom_addr", rom_addr, m_addr);
      chk("cyc_inc_data", inc_data, e_inc);
      chk("cyc_sample_valid", sample_valid, e_sv);
      chk("cyc_sample", sample, e_sample);
      chk("cyc_div_now", div_now, m_now);
      chk("cyc_at_min", at_min, e_min);
      chk("cyc_at_max", at_max, e_max);
      chk("cyc_running", running, e_run);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_inc(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!inc_data && n < 200);
  endtask

  task automatic press(input bit up, input bit dn);
    @(negedge clk); sw_up = up; sw_down = dn;
    @(negedge clk); sw_up = 1'b0; sw_down = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; sw_up = 1'b0; sw_down = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_div_now", div_now, 8);
    chk("rst_running", running, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_at_min", at_min, 0);
    chk("rst_at_max", at_max, 0);

    // Start: PRIME, then first advance after 8 RUN cycles.
    en = 1'b1;
    wait_inc(n);
    chk("first_inc_latency", n, 10);
    chk("first_addr", rom_addr, 1);
    wait_inc(n);
    chk("inc_period", n, 8);
    for (int k = 0; k < 13; k++) wait_inc(n);
    chk("addr_15", rom_addr, 15);
    wait_inc(n);
    chk("wrap_addr", rom_addr, 0);
    wait_inc(n);
    chk("post_wrap_addr", rom_addr, 1);

    // Drop en one clock after the advance: pending sample still arrives.
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("drop_sample_valid", sample_valid, 1);
    chk("drop_sample", sample, rom_val(1));
    chk("drop_running", running, 0);
    repeat (10) @(negedge clk);
    chk("freeze_addr", rom_addr, 1);
    en = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("reprime_valid", sample_valid, 1);
    chk("reprime_sample", sample, rom_val(1));
    @(negedge clk); en = 1'b0;

    // Rate adjust while idle.
    press(1'b0, 1'b1); press(1'b0, 1'b1); press(1'b0, 1'b1);
    chk("down3_div", div_now, 11);
    for (int k = 0; k < 200 && !at_max; k++) press(1'b0, 1'b1);
    chk("max_at_max", at_max, 1);
    chk("max_div", div_now, 50000);
    press(1'b0, 1'b1);
    chk("max_hold", div_now, 50000);
    press(1'b1, 1'b1);
    chk("both_ignored", div_now, 50000);
    press(1'b1, 1'b0);
    chk("up_from_max", div_now, 43750);
    chk("up_at_max_clear", at_max, 0);
    press(1'b1, 1'b0);
    chk("up_again", div_now, 38282);
    for (int k = 0; k < 300 && !at_min; k++) press(1'b1, 1'b0);
    chk("min_at_min", at_min, 1);
    chk("min_div", div_now, 4);
    press(1'b1, 1'b0);
    chk("min_hold", div_now, 4);

    // Mid-period change takes effect only at the next boundary.
    press(1'b0, 1'b1); press(1'b0, 1'b1);
    chk("div_6", div_now, 6);
    @(negedge clk); en = 1'b1;
    wait_inc(n);
    @(negedge clk); sw_down = 1'b1;
    @(negedge clk); sw_down = 1'b0;
    wait_inc(n);
    chk("mid_period_len", n, 5);
    wait_inc(n);
    chk("new_period_len", n, 7);
    chk("new_div", div_now, 7);

    // clr on the terminal-count cycle.
    repeat (7) @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_addr", rom_addr, 0);
    chk("clr_no_inc", inc_data, 0);
    @(negedge clk); clr = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("clr_valid", sample_valid, 1);
    chk("clr_sample", sample, rom_val(0));

    // Reset mid-run with a read in flight.
    wait_inc(n);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_addr", rom_addr, 0);
    chk("mrst_inc", inc_data, 0);
    chk("mrst_sample", sample, 0);
    chk("mrst_div", div_now, 8);
    chk("mrst_running", running, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_no_stale_valid", sample_valid, 0);
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
